// File: rtl/pc_gen_if.sv
// Fetch request channel between the PC generator and instruction memory.
// The master drives the address and valid; the memory side answers with ready.
interface pc_gen_if #(
    parameter int unsigned XLEN = 32
);
    logic            fetch_valid;
    logic            fetch_ready;
    logic [XLEN-1:0] pc_out;

    modport master (
        output fetch_valid,
        output pc_out,
        input  fetch_ready
    );

    modport slave (
        input  fetch_valid,
        input  pc_out,
        output fetch_ready
    );
endinterface

// File: rtl/pc_gen.sv
// RV32I fetch-stage program counter: sequential fetch, prioritised redirects with
// buffering while the request is stalled, halt/drain/resume and an accept counter.
module pc_gen #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned     CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    pc_gen_if.master         fetch_if,
    input  logic             i_br_taken,
    input  logic [XLEN-1:0]  i_br_target,
    input  logic             i_trap_req,
    input  logic             i_trap_ret,
    input  logic             i_halt_req,
    input  logic             i_resume,
    output logic [XLEN-1:0]  o_epc,
    output logic [XLEN-1:0]  o_bad_addr,
    output logic             o_misalign,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_fetch_count
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    // Redirect kinds, encoded so that a larger value means higher priority.
    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_BR   = 2'd1;
    localparam logic [1:0] K_RET  = 2'd2;
    localparam logic [1:0] K_TRAP = 2'd3;

    logic [1:0]       r_state;
    logic             r_valid;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_epc;
    logic [XLEN-1:0]  r_bad_addr;
    logic             r_misalign;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_pend_kind;
    logic [XLEN-1:0]  r_pend_tgt;
    logic             r_pend_mis;

    logic             w_accept;
    logic             w_blocked;
    logic             w_br_mis;
    logic [1:0]       w_new_kind;
    logic             w_new_mis;
    logic             w_take_new;
    logic [1:0]       w_kind;
    logic [XLEN-1:0]  w_tgt;
    logic             w_mis;
    logic             w_apply;
    logic [XLEN-1:0]  w_redirect_pc;
    logic [1:0]       w_state_d;

    assign w_accept  = r_valid & fetch_if.fetch_ready;
    assign w_blocked = r_valid & ~fetch_if.fetch_ready;
    assign w_br_mis  = (i_br_target[1:0] != 2'b00);

    always_comb begin
        w_new_kind = K_NONE;
        w_new_mis  = 1'b0;
        if (i_trap_req) begin
            w_new_kind = K_TRAP;
        end else if (i_trap_ret) begin
            w_new_kind = K_RET;
        end else if (i_br_taken) begin
            w_new_kind = w_br_mis ? K_TRAP : K_BR;
            w_new_mis  = w_br_mis;
        end
    end

    // A new request replaces the buffered one unless the buffered one outranks it.
    assign w_take_new = (w_new_kind != K_NONE) && (w_new_kind >= r_pend_kind);
    assign w_kind     = w_take_new ? w_new_kind  : r_pend_kind;
    assign w_tgt      = w_take_new ? i_br_target : r_pend_tgt;
    assign w_mis      = w_take_new ? w_new_mis   : r_pend_mis;
    assign w_apply    = (w_kind != K_NONE) && !w_blocked;

    always_comb begin
        unique case (w_kind)
            K_TRAP:  w_redirect_pc = TRAP_VECTOR;
            K_RET:   w_redirect_pc = r_epc;
            default: w_redirect_pc = w_tgt;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_RUN:   if (i_halt_req) w_state_d = w_blocked ? ST_DRAIN : ST_HALT;
            ST_DRAIN: if (w_accept) w_state_d = ST_HALT;
            ST_HALT:  if (i_resume && !i_halt_req) w_state_d = ST_RUN;
            default:  w_state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_valid     <= 1'b0;
            r_pc        <= RESET_VECTOR;
            r_epc       <= '0;
            r_bad_addr  <= '0;
            r_misalign  <= 1'b0;
            r_count     <= '0;
            r_pend_kind <= K_NONE;
            r_pend_tgt  <= '0;
            r_pend_mis  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_valid    <= (w_state_d != ST_HALT);
            r_misalign <= 1'b0;

            if (w_apply) begin
                r_pc <= w_redirect_pc;
                if (w_kind == K_TRAP) begin
                    r_epc <= r_pc;
                    if (w_mis) begin
                        r_bad_addr <= w_tgt;
                        r_misalign <= 1'b1;
                    end
                end
            end else if (w_accept) begin
                r_pc <= r_pc + XLEN'(4);
            end

            if (w_accept) begin
                r_count <= r_count + CNT_W'(1);
            end

            // While stalled the winner is held; otherwise it has just been applied.
            if (w_blocked) begin
                r_pend_kind <= w_kind;
                r_pend_tgt  <= w_tgt;
                r_pend_mis  <= w_mis;
            end else begin
                r_pend_kind <= K_NONE;
            end
        end
    end

    assign fetch_if.fetch_valid = r_valid;
    assign fetch_if.pc_out      = r_pc;
    assign o_epc                = r_epc;
    assign o_bad_addr           = r_bad_addr;
    assign o_misalign           = r_misalign;
    assign o_halted             = (r_state == ST_HALT);
    assign o_fetch_count        = r_count;

endmodule
